// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration logic.
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int OwnerW(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must be able to hold the value m.
   function automatic int BurstW(input int m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and UART-FIFO-side handshake of the transmit arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if #(
   parameter int NumReq     = 4,
   parameter int DataLength = 8
);

   logic [NumReq-1:0]                  i_req;
   logic [NumReq-1:0][DataLength-1:0]  i_data;
   logic [NumReq-1:0]                  i_last;
   logic [NumReq-1:0]                  o_gnt;
   logic                               o_tx_req;
   logic [DataLength-1:0]              o_tx_data;
   logic                               i_tx_rdy;

   modport slave (
      input  i_req,
      input  i_data,
      input  i_last,
      input  i_tx_rdy,
      output o_gnt,
      output o_tx_req,
      output o_tx_data
   );

   modport master (
      output i_req,
      output i_data,
      output i_last,
      output i_tx_rdy,
      input  o_gnt,
      input  o_tx_req,
      input  o_tx_data
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or above ptr, wrapping around, plus a flag saying whether any was found.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NumReq = 4
) (
   input  logic [NumReq-1:0]          req,
   input  logic [OwnerW(NumReq)-1:0]  ptr,
   output logic [OwnerW(NumReq)-1:0]  idx,
   output logic                       valid
);

   localparam int IdxW = OwnerW(NumReq);

   logic [IdxW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest asserted request wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         cand = IdxW'((int'(ptr) + i) % NumReq);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between several
// byte producers. A granted producer owns the port until it sends a byte
// flagged last or until it has sent MaxBurst bytes in this grant.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NumReq     = 4,
   parameter int DataLength = 8,
   parameter int MaxBurst   = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   uart_tx_arbiter_if.slave           arb,
   output logic                       o_busy,
   output logic [OwnerW(NumReq)-1:0]  o_owner
);

   localparam int OwnerWidth = OwnerW(NumReq);
   localparam int BurstWidth = BurstW(MaxBurst);
   localparam logic [BurstWidth-1:0] BurstLast = BurstWidth'(MaxBurst - 1);
   localparam logic [OwnerWidth-1:0] LastIdx   = OwnerWidth'(NumReq - 1);

   arb_state_e              state_q, state_d;
   logic [OwnerWidth-1:0]   owner_q, owner_d;
   logic [OwnerWidth-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BurstWidth-1:0]   burst_cnt_q, burst_cnt_d;

   logic [OwnerWidth-1:0]   pick_idx;
   logic                    pick_valid;
   logic                    tx_req;
   logic [DataLength-1:0]   tx_data;
   logic [NumReq-1:0]       gnt;

   rr_pick #(
      .NumReq (NumReq)
   ) u_rr_pick (
      .req   (arb.i_req),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Next-state logic plus the combinational write strobe toward the FIFO.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      tx_req      = 1'b0;
      tx_data     = '0;
      gnt         = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d     = pick_idx;
               burst_cnt_d = '0;
               state_d     = LOCK;
            end
         end
         LOCK: begin
            tx_req  = arb.i_req[owner_q] & arb.i_tx_rdy;
            tx_data = arb.i_data[owner_q];
            if (tx_req) begin
               gnt[owner_q] = 1'b1;
               burst_cnt_d  = burst_cnt_q + 1'b1;
               if (arb.i_last[owner_q] || (burst_cnt_q == BurstLast)) begin
                  state_d  = IDLE;
                  rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any message in flight immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Drive the interface and status outputs from the combinational results.
   always_comb begin
      arb.o_tx_req  = tx_req;
      arb.o_tx_data = tx_data;
      arb.o_gnt     = gnt;
      o_busy        = (state_q == LOCK);
      o_owner       = owner_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by a
// randomized phase, all checked against a message-level reference model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NumReq     = 4;
   localparam int DataLength = 8;
   localparam int MaxBurst   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [1:0] owner;

   uart_tx_arbiter_if #(.NumReq(NumReq), .DataLength(DataLength)) bus ();

   uart_tx_arbiter #(
      .NumReq     (NumReq),
      .DataLength (DataLength),
      .MaxBurst   (MaxBurst)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .arb     (bus),
      .o_busy  (busy),
      .o_owner (owner)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   byte unsigned pq_data[NumReq][$];
   bit           pq_last[NumReq][$];
   byte unsigned exp_sent[NumReq][$];
   byte unsigned got_sent[NumReq][$];
   int           gnt_log[$];
   int           gnt_cyc[$];
   int           data_log[$];
   bit           req_en[NumReq];
   bit           tx_rdy;

   // Reference model: who holds the port, where the next search starts,
   // the last owner reported, and bytes sent in the current grant.
   int m_holder;
   int m_next;
   int m_owner;
   int m_count;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int log_at(int k);
      return (k < gnt_log.size()) ? gnt_log[k] : -1;
   endfunction

   function automatic int data_at(int k);
      return (k < data_log.size()) ? data_log[k] : -1;
   endfunction

   function automatic int cyc_gap(int k);
      return (k + 1 < gnt_cyc.size()) ? gnt_cyc[k+1] - gnt_cyc[k] : -1;
   endfunction

   function automatic int pending();
      int n = 0;
      for (int r = 0; r < NumReq; r++) n += pq_data[r].size();
      return n;
   endfunction

   task automatic push_byte(int r, byte unsigned d, bit last);
      pq_data[r].push_back(d);
      pq_last[r].push_back(last);
      exp_sent[r].push_back(d);
   endtask

   task automatic push_msg(int r, int len, bit with_last);
      for (int k = 0; k < len; k++)
         push_byte(r, 8'($urandom_range(0, 255)), with_last && (k == len - 1));
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < NumReq; r++) begin
         bus.i_req[r]  = req_en[r] && (pq_data[r].size() != 0);
         bus.i_data[r] = 8'h00;
         bus.i_last[r] = 1'b0;
         if (pq_data[r].size() != 0) begin
            bus.i_data[r] = pq_data[r][0];
            bus.i_last[r] = pq_last[r][0];
         end
      end
      bus.i_tx_rdy = tx_rdy;
   endtask

   // One clock cycle: drive producers, check outputs, let producers and the
   // FIFO react to what the DUT did, then advance the reference model.
   task automatic applyStimulus();
      logic       exp_req;
      logic [7:0] exp_data;
      logic [3:0] exp_gnt;
      logic       exp_last;
      @(negedge clk);
      drive_inputs();
      #1;
      exp_req  = 1'b0;
      exp_data = 8'h00;
      exp_gnt  = 4'h0;
      exp_last = 1'b0;
      if (m_holder >= 0) begin
         exp_req  = bus.i_req[m_holder] && tx_rdy;
         exp_data = bus.i_data[m_holder];
         exp_last = bus.i_last[m_holder];
         if (exp_req) exp_gnt[m_holder] = 1'b1;
      end
      checkOutput("tx_req", bus.o_tx_req, exp_req);
      checkOutput("tx_data", bus.o_tx_data, exp_data);
      checkOutput("gnt", bus.o_gnt, exp_gnt);
      checkOutput("busy", busy, m_holder >= 0);
      checkOutput("owner", owner, m_owner);
      if (bus.o_tx_req) data_log.push_back(bus.o_tx_data);
      for (int r = 0; r < NumReq; r++) begin
         if (bus.o_gnt[r] && pq_data[r].size() != 0) begin
            got_sent[r].push_back(bus.o_tx_data);
            gnt_log.push_back(r);
            gnt_cyc.push_back(cyc);
            void'(pq_data[r].pop_front());
            void'(pq_last[r].pop_front());
         end
      end
      if (m_holder < 0) begin
         for (int k = 0; k < NumReq; k++) begin
            if (m_holder < 0 && bus.i_req[(m_next + k) % NumReq]) begin
               m_holder = (m_next + k) % NumReq;
               m_owner  = m_holder;
               m_count  = 0;
            end
         end
      end else if (exp_req) begin
         m_count++;
         if (exp_last || m_count == MaxBurst) begin
            m_next   = (m_holder + 1) % NumReq;
            m_holder = -1;
         end
      end
      cyc++;
   endtask

   task automatic run_until_log(int n, int budget, string tag);
      int k = 0;
      while (gnt_log.size() < n && k < budget) begin
         applyStimulus();
         k++;
      end
      checkOutput({tag, "_timeout"}, gnt_log.size() >= n, 1'b1);
   endtask

   task automatic scoreboard_check(bit full);
      for (int r = 0; r < NumReq; r++) begin
         if (full) checkOutput($sformatf("sb_count_r%0d", r), got_sent[r].size(), exp_sent[r].size());
         else      checkOutput($sformatf("sb_overrun_r%0d", r), got_sent[r].size() <= exp_sent[r].size(), 1'b1);
         for (int k = 0; k < got_sent[r].size() && k < exp_sent[r].size(); k++)
            checkOutput($sformatf("sb_r%0d_b%0d", r, k), got_sent[r][k], exp_sent[r][k]);
      end
   endtask

   // Asserts reset asynchronously wherever the bench currently is in the
   // cycle, checks outputs clear at once, then clears all bench state.
   task automatic do_reset(bit full);
      scoreboard_check(full);
      rst = 1'b1;
      #1;
      checkOutput("rst_tx_req", bus.o_tx_req, 1'b0);
      checkOutput("rst_gnt", bus.o_gnt, 4'h0);
      checkOutput("rst_tx_data", bus.o_tx_data, 8'h00);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_owner", owner, 2'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int r = 0; r < NumReq; r++) begin
         pq_data[r].delete();
         pq_last[r].delete();
         exp_sent[r].delete();
         got_sent[r].delete();
         req_en[r] = 1'b1;
      end
      gnt_log.delete();
      gnt_cyc.delete();
      data_log.delete();
      tx_rdy   = 1'b1;
      m_holder = -1;
      m_next   = 0;
      m_owner  = 0;
      m_count  = 0;
      drive_inputs();
      #2 rst = 1'b0;
   endtask

   initial begin
      bus.i_req    = '0;
      bus.i_data   = '0;
      bus.i_last   = '0;
      bus.i_tx_rdy = 1'b0;
      do_reset(1'b1);

      // Single message from requester 2, then requester 3 must win next.
      push_byte(2, 8'hA5, 1'b0);
      push_byte(2, 8'h3C, 1'b0);
      push_byte(2, 8'h7E, 1'b1);
      run_until_log(3, 20, "single");
      for (int k = 0; k < 3; k++) checkOutput($sformatf("single_gnt%0d", k), log_at(k), 2);
      checkOutput("single_d0", data_at(0), 32'hA5);
      checkOutput("single_d1", data_at(1), 32'h3C);
      checkOutput("single_d2", data_at(2), 32'h7E);
      checkOutput("single_gap0", cyc_gap(0), 1);
      checkOutput("single_gap1", cyc_gap(1), 1);
      applyStimulus();
      checkOutput("single_idle", busy, 1'b0);
      push_byte(0, 8'h11, 1'b1);
      push_byte(3, 8'h33, 1'b1);
      run_until_log(5, 20, "after_single");
      checkOutput("rr_ptr_next", log_at(3), 3);
      checkOutput("rr_ptr_then", log_at(4), 0);
      do_reset(1'b1);

      // All four send a one-byte message together: order 0..3, bubble between.
      for (int r = 0; r < NumReq; r++) push_msg(r, 1, 1'b1);
      run_until_log(4, 30, "rr");
      for (int k = 0; k < 4; k++) checkOutput($sformatf("rr_order%0d", k), log_at(k), k);
      for (int k = 0; k < 3; k++) checkOutput($sformatf("rr_gap%0d", k), cyc_gap(k), 2);
      do_reset(1'b1);

      // Requester 0 arrives mid-message of requester 1 and must wait.
      push_msg(1, 4, 1'b1);
      run_until_log(1, 20, "atom_start");
      push_msg(0, 1, 1'b1);
      run_until_log(5, 30, "atom");
      for (int k = 0; k < 4; k++) checkOutput($sformatf("atom_r1_%0d", k), log_at(k), 1);
      checkOutput("atom_r0", log_at(4), 0);
      checkOutput("atom_gap", cyc_gap(3), 2);
      do_reset(1'b1);

      // Burst limit: 16 bytes of requester 0, requester 3, then 0's remainder.
      push_msg(0, 20, 1'b1);
      push_msg(3, 2, 1'b1);
      run_until_log(22, 80, "burst");
      for (int k = 0; k < 22; k++)
         checkOutput($sformatf("burst_gnt%0d", k), log_at(k), (k == 16 || k == 17) ? 3 : 0);
      do_reset(1'b1);

      // Backpressure for 10 cycles mid-message.
      push_msg(1, 6, 1'b1);
      run_until_log(2, 20, "bp_start");
      tx_rdy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus();
         checkOutput("bp_tx_req", bus.o_tx_req, 1'b0);
         checkOutput("bp_gnt", bus.o_gnt, 4'h0);
      end
      checkOutput("bp_stalled", gnt_log.size(), 2);
      tx_rdy = 1'b1;
      run_until_log(6, 20, "bp_end");
      do_reset(1'b1);

      // Reset after byte 1 of 3, while byte 2 is being offered.
      push_msg(2, 3, 1'b1);
      run_until_log(1, 20, "mid_rst");
      @(negedge clk);
      drive_inputs();
      #1;
      checkOutput("pre_rst_tx_req", bus.o_tx_req, 1'b1);
      do_reset(1'b0);
      push_msg(3, 1, 1'b1);
      push_msg(2, 1, 1'b1);
      push_msg(0, 1, 1'b1);
      run_until_log(3, 20, "post_rst");
      checkOutput("post_rst_first", log_at(0), 0);
      do_reset(1'b1);

      // Randomized traffic with gaps and backpressure, then drain.
      for (int c = 0; c < 1500; c++) begin
         tx_rdy = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < NumReq; r++) begin
            req_en[r] = ($urandom_range(0, 7) != 0);
            if (pq_data[r].size() == 0 && $urandom_range(0, 9) == 0)
               push_msg(r, $urandom_range(1, 20), 1'b1);
         end
         applyStimulus();
      end
      tx_rdy = 1'b1;
      for (int r = 0; r < NumReq; r++) req_en[r] = 1'b1;
      for (int k = 0; k < 800 && pending() != 0; k++) applyStimulus();
      checkOutput("drain_timeout", pending(), 0);
      scoreboard_check(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port (`i_tx_data`/`i_tx_req`/`o_tx_rdy` of `uart`) between `NumReq` independent byte producers. It uses round-robin arbitration and keeps messages atomic: a granted requester keeps the port until it sends a byte marked last, or until it hits a fairness burst limit. The block sits between the producers and `uart`, and drives the UART write handshake directly.

## Interface
Parameters:
- `NumReq`, 4: number of requesters (≥2).
- `DataLength`, 8: byte width; must match `uart`.
- `MaxBurst`, 16: maximum bytes per grant before forced release (≥1).

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  NumReq  per-requester "byte valid".
- `i_data`  in  NumReq×DataLength  per-requester byte.
- `i_last`  in  NumReq  byte is the final byte of its message.
- `o_gnt`  out  NumReq  one-hot; byte of that requester accepted this cycle.
- `o_tx_req`  out  1  write strobe to the UART TX FIFO.
- `o_tx_data`  out  DataLength  byte to the UART TX FIFO.
- `i_tx_rdy`  in  1  UART TX FIFO can accept (`o_tx_rdy` of `uart`).
- `o_busy`  out  1  a requester holds the lock.
- `o_owner`  out  $clog2(NumReq)  index of the current or last owner.

## Operation
- The FSM has two states: IDLE and LOCK. Registers: `state`, `owner`, `rr_ptr`, `burst_cnt` (width $clog2(MaxBurst+1)).
- **IDLE:** if any `i_req` is high, pick the first asserted index scanning upward from `rr_ptr`, wrapping modulo NumReq. Load `owner`, clear `burst_cnt`, and go to LOCK. No transfer happens in IDLE.
- **LOCK:** `o_tx_req = i_req[owner] & i_tx_rdy`; `o_tx_data = i_data[owner]`; `o_gnt[owner] = o_tx_req`. All are combinational. A transfer is any cycle in which `o_tx_req` is high.
- On each transfer, `burst_cnt` increments.
- **Release** happens on a transfer where `i_last[owner]` is high, or where `burst_cnt == MaxBurst-1`. On release:
  - state goes to IDLE;
  - `rr_ptr` becomes `(owner+1) mod NumReq`.
- If `i_last` and the burst limit coincide on the same byte, the block releases once.
- Non-owner `i_req`, `i_data` and `i_last` are ignored while in LOCK. Their `o_gnt` bits stay 0.
- If the owner drops `i_req` while in LOCK, the lock is held. Producers must complete their messages.
- `o_tx_req` is never high while `i_tx_rdy` is low, so a full UART FIFO is never written.
- `o_busy` = (state == LOCK). `o_owner` = `owner`.
- A forced release after MaxBurst bytes does not discard anything. The interrupted requester re-arbitrates normally and continues its message in a later grant.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `burst_cnt` 0. All outputs 0: `o_gnt`, `o_tx_req`, `o_tx_data`, `o_busy`, `o_owner`.
- Asserting `i_rst` mid-message clears everything immediately, without waiting for a clock edge. `o_tx_req` falls combinationally. The partial message is abandoned.
- **Grant latency:** `i_req` sampled high in IDLE at edge N gives LOCK from edge N. The first byte transfers in cycle N+1 if `i_tx_rdy` is high.
- **Throughput in LOCK:** one byte per cycle while `i_req[owner]` and `i_tx_rdy` are both high.
- **Release bubble:** there is one IDLE cycle between consecutive grants. A message of k bytes therefore occupies at least k+1 cycles.
- **Producer rule:** hold `i_data` and `i_last` stable while `i_req` is high until `o_gnt` is seen. Advance to the next byte the cycle after `o_gnt`.

## Structure
- Shared package `uart_pkg` holds:
  - the `arb_state_e` enum (IDLE, LOCK);
  - the `OwnerW` and `BurstW` width functions.
- One sub-module: `rr_pick`. It is a combinational round-robin priority picker that takes `req`, `ptr` and returns the index plus a valid flag. It is reusable for the RX side later.

## Test plan
- **Single message:** requester 2 sends 0xA5, 0x3C, 0x7E (last on 0x7E) with `i_tx_rdy`=1. Expect 3 `o_gnt[2]` pulses, then `o_tx_data` sequence A5,3C,7E, then IDLE; `rr_ptr`=3.
- **Round-robin:** all 4 requesters each send a one-byte message at the same time, starting from reset. Expect grant order 0,1,2,3, then a bubble cycle between each grant.
- **Atomicity:** requester 1 sends a 4-byte message, and requester 0 asserts `i_req` during byte 2. Expect no `o_gnt[0]` until requester 1's last byte plus one idle cycle.
- **Burst limit:** with MaxBurst=16, requester 0 streams 20 bytes with no `i_last`, while requester 3 is waiting. Expect release after byte 16, requester 3 served next, and requester 0 finishing bytes 17–20 afterwards.
- **Backpressure:** hold `i_tx_rdy` low for 10 cycles mid-message. Expect `o_tx_req`=0 and `o_gnt`=0 throughout, then resumption with no lost or duplicated bytes.
- **Reset mid-message:** assert `i_rst` after byte 1 of 3. Expect all outputs 0 the same cycle and `rr_ptr`=0. After reset, requester 0 has priority.
